// File: rtl/idma_copy_sched.sv
// Copy-descriptor scheduler: round-robin between two requesters, one iDMA copy in flight.
// Define IDMA_SCHED_TIMEOUT_EN to add a WAIT-state watchdog that completes the copy with an error.
module idma_copy_sched #(
  parameter int unsigned AXI_ADDR_WID = 32,
  parameter int unsigned NUM_WID      = 32,
  parameter int unsigned TO_WID       = 16
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [1:0]                cmd_valid,
  output logic [1:0]                cmd_ready,
  input  logic [2*AXI_ADDR_WID-1:0] cmd_src,
  input  logic [2*AXI_ADDR_WID-1:0] cmd_dst,
  input  logic [2*NUM_WID-1:0]      cmd_num,
  output logic [1:0]                cmd_done,
  output logic [1:0]                cmd_err,
  output logic                      rd_req,
  output logic [AXI_ADDR_WID-1:0]   rd_addr,
  output logic [NUM_WID-1:0]        rd_num,
  input  logic                      rd_addr_ready,
  input  logic                      rd_done_intr,
  output logic                      wr_req,
  output logic [AXI_ADDR_WID-1:0]   wr_addr,
  output logic [NUM_WID-1:0]        wr_num,
  input  logic                      wr_addr_ready,
  input  logic                      wr_done_intr,
  output logic                      busy,
  output logic                      owner
);

  localparam int unsigned AW = AXI_ADDR_WID;
  localparam int unsigned NW = NUM_WID;

  if (TO_WID == 0) begin : g_bad_to_wid
    $error("TO_WID must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            last_q, last_d;
  logic            owner_d, busy_d;
  logic [1:0]      ready_d, done_d, err_out_d;
  logic            rd_req_d, wr_req_d;
  logic [AW-1:0]   src_q, src_d, dst_q, dst_d;
  logic [NW-1:0]   num_q, num_d;
  logic            err_q, err_d;
  logic            rd_acc_q, rd_acc_d, wr_acc_q, wr_acc_d;
  logic            rd_seen_q, rd_seen_d, wr_seen_q, wr_seen_d;
  logic            gnt, rd_acc_nx, wr_acc_nx;
`ifdef IDMA_SCHED_TIMEOUT_EN
  logic [TO_WID-1:0] to_cnt_q, to_cnt_d;
`endif

  assign rd_addr = src_q;
  assign wr_addr = dst_q;
  assign rd_num  = num_q;
  assign wr_num  = num_q;

  // Next-state and registered-output decode
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner;
    ready_d   = 2'b00;
    done_d    = 2'b00;
    err_out_d = 2'b00;
    rd_req_d  = 1'b0;
    wr_req_d  = 1'b0;
    src_d     = src_q;
    dst_d     = dst_q;
    num_d     = num_q;
    err_d     = err_q;
    rd_acc_d  = rd_acc_q;
    wr_acc_d  = wr_acc_q;
    rd_seen_d = rd_seen_q;
    wr_seen_d = wr_seen_q;
`ifdef IDMA_SCHED_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
`endif
    gnt       = (cmd_valid == 2'b11) ? ~last_q : cmd_valid[1];
    rd_acc_nx = rd_acc_q | (rd_req & rd_addr_ready);
    wr_acc_nx = wr_acc_q | (wr_req & wr_addr_ready);

    case (state_q)
      S_IDLE: begin
        if (|cmd_valid) begin
          ready_d[gnt] = 1'b1;
          owner_d      = gnt;
          last_d       = gnt;
          src_d        = gnt ? cmd_src[AW +: AW] : cmd_src[0 +: AW];
          dst_d        = gnt ? cmd_dst[AW +: AW] : cmd_dst[0 +: AW];
          num_d        = gnt ? cmd_num[NW +: NW] : cmd_num[0 +: NW];
          err_d        = (num_d == '0);
          rd_acc_d     = 1'b0;
          wr_acc_d     = 1'b0;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        rd_seen_d = rd_seen_q | rd_done_intr;
        wr_seen_d = wr_seen_q | wr_done_intr;
        // A zero-length descriptor passes straight through to DONE without raising requests
        if (err_q) begin
          state_d = S_DONE;
        end else begin
          rd_acc_d = rd_acc_nx;
          wr_acc_d = wr_acc_nx;
          rd_req_d = ~rd_acc_nx;
          wr_req_d = ~wr_acc_nx;
          if (rd_acc_nx && wr_acc_nx) begin
            state_d = S_WAIT;
`ifdef IDMA_SCHED_TIMEOUT_EN
            to_cnt_d = '0;
`endif
          end
        end
      end
      S_WAIT: begin
        rd_seen_d = rd_seen_q | rd_done_intr;
        wr_seen_d = wr_seen_q | wr_done_intr;
        if (rd_seen_q && wr_seen_q) begin
          state_d = S_DONE;
        end
`ifdef IDMA_SCHED_TIMEOUT_EN
        else if (to_cnt_q == '1) begin
          state_d = S_DONE;
          err_d   = ~(rd_seen_d & wr_seen_d);
        end
        to_cnt_d = to_cnt_q + TO_WID'(1);
`endif
      end
      S_DONE: begin
        done_d[owner]    = 1'b1;
        err_out_d[owner] = err_q;
        err_d            = 1'b0;
        rd_seen_d        = 1'b0;
        wr_seen_d        = 1'b0;
        state_d          = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      owner     <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 2'b00;
      cmd_done  <= 2'b00;
      cmd_err   <= 2'b00;
      rd_req    <= 1'b0;
      wr_req    <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      num_q     <= '0;
      err_q     <= 1'b0;
      rd_acc_q  <= 1'b0;
      wr_acc_q  <= 1'b0;
      rd_seen_q <= 1'b0;
      wr_seen_q <= 1'b0;
`ifdef IDMA_SCHED_TIMEOUT_EN
      to_cnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner     <= owner_d;
      busy      <= busy_d;
      cmd_ready <= ready_d;
      cmd_done  <= done_d;
      cmd_err   <= err_out_d;
      rd_req    <= rd_req_d;
      wr_req    <= wr_req_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      num_q     <= num_d;
      err_q     <= err_d;
      rd_acc_q  <= rd_acc_d;
      wr_acc_q  <= wr_acc_d;
      rd_seen_q <= rd_seen_d;
      wr_seen_q <= wr_seen_d;
`ifdef IDMA_SCHED_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
`endif
    end
  end

endmodule
